// File: rtl/ah_func_seq.sv
// ---------------------------------------------------------------------------
// ah_func_seq
//
// Purpose: Nios custom-instruction sequencer that drives a pipelined
// floating-point function unit. On start it issues N operands
// float(0), float(1), ..., float(N-1) together with a latched seed. It then
// waits out the unit's pipeline latency, captures the result of the last
// issue and pulses done. A zero issue count returns the seed directly.
//
// Parameters:
//   LATENCY  function-unit pipeline depth in cycles (>= 1)
//   NMAX     maximum issue count (power of two, <= 2^24)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   clk_en     custom-instruction clock enable; low freezes all state
//   start      custom-instruction start strobe (sampled in IDLE only)
//   dataa      issue count N (unsigned, clamped to NMAX)
//   datab      IEEE-754 single seed
//   result     IEEE-754 single captured from the last issue
//   done       one-cycle completion pulse
//   fu_dataa   float(i) operand to the function unit
//   fu_datab   latched seed to the function unit
//   fu_clk_en  function-unit pipeline advance enable
//   fu_reset   function-unit reset (pass-through of reset)
//   fu_result  function-unit output
// ---------------------------------------------------------------------------
module ah_func_seq #(
    parameter int LATENCY = 64,
    parameter int NMAX    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic [31:0] fu_dataa,
    output logic [31:0] fu_datab,
    output logic        fu_clk_en,
    output logic        fu_reset,
    input  logic [31:0] fu_result
);

    // i covers 0..NMAX-1, the clamped count covers 0..NMAX,
    // the drain counter covers 0..LATENCY.
    localparam int IW = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int NW = $clog2(NMAX) + 1;
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    localparam logic [31:0]   NMAX_W    = 32'(NMAX);
    localparam logic [NW-1:0] NMAX_N    = NW'(NMAX);
    localparam logic [DW-1:0] LATENCY_D = DW'(LATENCY);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_reg;
    logic [IW-1:0] i_reg;
    logic [NW-1:0] ncap_reg;
    logic [DW-1:0] drain_reg;
    logic [31:0]   seed_reg;
    logic [31:0]   result_reg;

    logic [NW-1:0] ncap_next;
    logic          last_issue;
    logic [31:0]   i_float;

    // Clamp the requested count to NMAX before it is latched.
    always_comb begin
        ncap_next = (dataa > NMAX_W) ? NMAX_N : dataa[NW-1:0];
    end

    // The last issue is the one with i = Ncap-1 (Ncap is never 0 in ISSUE).
    always_comb begin
        last_issue = (NW'(i_reg) == (ncap_reg - NW'(1)));
    end

    // Exact integer-to-single conversion. Every i fits in 24 bits, so the
    // value is representable without rounding: locate the leading one,
    // normalise it into the hidden-bit position and drop it.
    always_comb begin
        logic [23:0] iv;
        logic [23:0] shifted;
        logic [4:0]  p;
        iv      = 24'(i_reg);
        p       = 5'd0;
        for (int b = 0; b < 24; b++) begin
            if (iv[b]) begin
                p = b[4:0];
            end
        end
        shifted = iv << (5'd23 - p);
        if (iv == 24'd0) begin
            i_float = 32'h0000_0000;
        end else begin
            i_float = {1'b0, 8'd127 + {3'b000, p}, shifted[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            i_reg      <= '0;
            ncap_reg   <= '0;
            drain_reg  <= '0;
            seed_reg   <= '0;
            result_reg <= '0;
        end else if (clk_en) begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        seed_reg <= datab;
                        ncap_reg <= ncap_next;
                        i_reg    <= '0;
                        if (ncap_next == '0) begin
                            result_reg <= datab;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_issue) begin
                        // i stays put so it never wraps at Ncap = NMAX.
                        drain_reg <= LATENCY_D;
                        state_reg <= S_DRAIN;
                    end else begin
                        i_reg <= i_reg + IW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_reg <= drain_reg - DW'(1);
                    // Counter at 1 is exactly LATENCY enabled cycles after
                    // the last issue, when its result sits on fu_result.
                    if (drain_reg == DW'(1)) begin
                        result_reg <= fu_result;
                        state_reg  <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // The function unit advances only in enabled ISSUE/DRAIN cycles, keeping
    // its pipeline in step with the drain counter across stalls.
    always_comb begin
        done      = (state_reg == S_DONE);
        fu_clk_en = clk_en && ((state_reg == S_ISSUE) || (state_reg == S_DRAIN));
        fu_dataa  = (state_reg == S_ISSUE) ? i_float : 32'h0000_0000;
        fu_datab  = seed_reg;
        fu_reset  = reset;
        result    = result_reg;
    end

endmodule
